exu_alu_pipe: RTL
=================

// Module: exu_alu_pipe
// PURPOSE
//  Parametrised, pipelined integer ALU and branch-resolution unit for the EXU.
//  Accepts one op per cycle on a valid/ready handshake and returns the result after STAGES cycles.
//  Each result carries the branch outcome, the mispredict flag and the flush path.
//  Supports pipeline back-pressure, whole-pipe flush and a saturating mispredict counter.
//  Replaces the fixed 32-bit, single-stage ALU control in the EXU pipe.
// PARAMETERS
//  XLEN     32   operand/result width; legal values 32 or 64
//  STAGES   1    cycles from accept to out_valid; legal range 1..3
//  CNTW     16   width of the mispredict counter
// PORTS
//  clk          in   1          clock; all state updates on its rising edge
//  rst          in   1          synchronous, active-high reset
//  flush        in   1          kill all in-flight ops; no op is accepted in the same cycle
//  in_valid     in   1          request valid
//  in_ready     out  1          request accepted when in_valid & in_ready
//  in_op        in   alu_op_e   operation (from exu_alu_pkg)
//  in_a         in   XLEN       rs1 operand, or pc for jal
//  in_b         in   XLEN       rs2 operand or immediate
//  in_pc        in   XLEN-1     pc[XLEN-1:1]
//  in_brimm     in   12         branch offset [12:1]
//  in_pred_t    in   1          branch predicted taken
//  in_pc4       in   1          1: link = pc+4; 0: link = pc+2
//  out_valid    out  1          result valid
//  out_ready    in   1          consumer ready
//  out_result   out  XLEN       ALU result, or link address for jal
//  out_taken    out  1          actual branch/jump taken
//  out_misp     out  1          mispredict (conditional branch) or jal redirect
//  out_path     out  XLEN-1     redirect pc[XLEN-1:1]
//  misp_cnt     out  CNTW       saturating count of delivered mispredicts
// BEHAVIOUR
//  - Reset:
//    - All stage valids clear; in_ready=1; out_valid=0.
//    - out_result, out_path, out_taken and out_misp read 0.
//    - misp_cnt=0.
//  - Compute:
//    - Operands are registered at accept; compute happens in stage 1.
//    - Stages 2..STAGES only carry the result.
//    - Latency is exactly STAGES cycles with out_ready held at 1.
//  - Handshake (per stage, including the input):
//    - ready_k = ~valid_k | ready_{k+1}; ready_{STAGES+1} = out_ready.
//    - A stage holds its contents while its successor is stalled.
//    - in_ready = ready_1 & ~flush.
//    - Full throughput (1 op/cycle) with out_ready=1.
//    - out_valid held with out_ready=0 keeps all out_* stable.
//  - Flush: all stage valids clear at the next edge, including an op presented on out_valid that cycle.
//  - Arithmetic:
//    - add/sub are modulo 2^XLEN.
//    - slt/sltu produce {XLEN-1 zeros, lt}; signed lt = neg^ov; unsigned lt = ~carry of a-b.
//    - sll/srl/sra shift by b[log2(XLEN)-1:0].
//  - Branches:
//    - beq/bne/blt/bge/bltu/bgeu compare a and b.
//    - Target = pc + sext(brimm), modulo 2^(XLEN-1), in half-word units.
//    - out_path = target when taken, else pc + (in_pc4 ? 2 : 1).
//    - out_misp = pred_t ^ taken.
//    - Branch ops drive out_result = 0.
//  - jal/jalr:
//    - out_taken=1, out_misp=1.
//    - out_path = (a+b)[XLEN-1:1]; out_result = link address.
//  - misp_cnt:
//    - Increments on out_valid & out_ready & out_misp & ~flush.
//    - Holds at 2^CNTW-1 (no wrap).
//  - Simultaneous events: rst beats flush; flush beats accept and deliver.
// CONFIGURATION
//  - EXU_ALU_BITMANIP_EN defined:
//    - Adds ops andn, orn, xnor, min, minu, max, maxu (alu_op_e encodings present).
//    - min/max use the same lt path as slt.
//  - Undefined:
//    - Those ops produce out_result=0, taken=0, misp=0.
//    - No added logic.
// STRUCTURE
//  - exu_alu_pkg holds:
//    - alu_op_e;
//    - alu_req_t (op, a, b, pc, brimm, pred_t, pc4);
//    - alu_rsp_t (result, taken, misp, path);
//    - constants STAGES_MAX=3, BRIMM_W=12.
//  - Sub-module exu_alu_stage: one register stage with valid/ready, flush and rst.
//    - Parametrised on payload type.
//    - Instantiated STAGES times via generate; stage 1 carries alu_req_t, later stages alu_rsp_t.
// TESTING
//  1. STAGES=2, add a=5 b=7, out_ready=1 -> out_valid two cycles after accept; result 12.
//  2. sub a=0 b=1 -> result all ones; sltu a=1 b=-1 -> 1; slt a=1 b=-1 -> 0.
//  3. bne a=1 b=2, pc=0x100>>1, brimm=0x10>>1, pred_t=0 -> taken=1, misp=1, path=0x110>>1; misp_cnt +1.
//  4. Back-pressure: 4 back-to-back adds, out_ready=0 for 5 cycles.
//     -> in_ready drops after STAGES ops; results delivered in order, none lost.
//  5. Flush with 2 ops in flight plus in_valid the same cycle -> no out_valid afterwards; misp_cnt unchanged.
//  6. CNTW=2: five delivered mispredicts -> misp_cnt=3; rst mid-stream -> all valids 0, misp_cnt=0.

Source files
------------

// File: rtl/exu_alu_pkg.sv
// Shared types and constants for the pipelined EXU ALU / branch unit.
// Bitmanip op encodings always exist; their datapath is built only with EXU_ALU_BITMANIP_EN.
package exu_alu_pkg;

  localparam int unsigned XLEN_MAX   = 64;
  localparam int unsigned STAGES_MAX = 3;
  localparam int unsigned BRIMM_W    = 12;

  typedef enum logic [4:0] {
    OP_ADD  = 5'd0,
    OP_SUB,
    OP_SLT,
    OP_SLTU,
    OP_SLL,
    OP_SRL,
    OP_SRA,
    OP_AND,
    OP_OR,
    OP_XOR,
    OP_BEQ,
    OP_BNE,
    OP_BLT,
    OP_BGE,
    OP_BLTU,
    OP_BGEU,
    OP_JAL,
    OP_JALR,
    OP_ANDN,
    OP_ORN,
    OP_XNOR,
    OP_MIN,
    OP_MINU,
    OP_MAX,
    OP_MAXU
  } alu_op_e;

  // Payloads are sized for the widest legal XLEN; narrower builds use the low bits.
  typedef struct packed {
    alu_op_e               op;
    logic [XLEN_MAX-1:0]   a;
    logic [XLEN_MAX-1:0]   b;
    logic [XLEN_MAX-2:0]   pc;
    logic [BRIMM_W-1:0]    brimm;
    logic                  pred_t;
    logic                  pc4;
  } alu_req_t;

  typedef struct packed {
    logic [XLEN_MAX-1:0]   result;
    logic                  taken;
    logic                  misp;
    logic [XLEN_MAX-2:0]   path;
  } alu_rsp_t;

endpackage

// File: rtl/exu_alu_stage.sv
// One valid/ready pipeline register stage, generic over its payload type.
// Holds its contents while the successor stalls; flush and rst drop the valid bit.
module exu_alu_stage #(
  parameter type T = logic [31:0]
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  input  logic in_valid,
  input  T     in_data,
  output logic out_valid,
  output T     out_data,
  input  logic out_ready
);

  logic load_c;

  assign load_c = ~out_valid | out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (load_c) begin
      out_valid <= in_valid;
      if (in_valid) out_data <= in_data;
    end
  end

endmodule

// File: rtl/exu_alu_pipe.sv
// Pipelined integer ALU and branch-resolution unit with back-pressure, flush and mispredict counter.
// Optional bitmanip ops (andn/orn/xnor/min/minu/max/maxu) are enabled by defining EXU_ALU_BITMANIP_EN.
module exu_alu_pipe
  import exu_alu_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned STAGES = 1,
  parameter int unsigned CNTW   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  alu_op_e           in_op,
  input  logic [XLEN-1:0]   in_a,
  input  logic [XLEN-1:0]   in_b,
  input  logic [XLEN-2:0]   in_pc,
  input  logic [11:0]       in_brimm,
  input  logic              in_pred_t,
  input  logic              in_pc4,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_result,
  output logic              out_taken,
  output logic              out_misp,
  output logic [XLEN-2:0]   out_path,
  output logic [CNTW-1:0]   misp_cnt
);

  localparam int unsigned SHW = $clog2(XLEN);

  logic [STAGES:1]   v;
  logic [STAGES+1:1] rdy;
  alu_req_t          req_d;
  alu_req_t          req_q;
  alu_rsp_t          rsp_c;
  alu_rsp_t          rsp_q [1:STAGES];

  // Ready chain computed from the valids alone so it never loops back on itself.
  always_comb begin
    rdy = '0;
    rdy[STAGES+1] = out_ready;
    for (int k = STAGES; k >= 1; k--) rdy[k] = ~v[k] | rdy[k+1];
  end

  assign in_ready = rdy[1] & ~flush;

  always_comb begin
    req_d        = '0;
    req_d.op     = in_op;
    req_d.a      = XLEN_MAX'(in_a);
    req_d.b      = XLEN_MAX'(in_b);
    req_d.pc     = (XLEN_MAX-1)'(in_pc);
    req_d.brimm  = in_brimm;
    req_d.pred_t = in_pred_t;
    req_d.pc4    = in_pc4;
  end

  exu_alu_stage #(.T(alu_req_t)) u_stage1 (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_data   (req_d),
    .out_valid (v[1]),
    .out_data  (req_q),
    .out_ready (rdy[2])
  );

  // Compute on the stage-1 registered operands.
  logic [XLEN-1:0] a, b, sum, diff, res;
  logic [XLEN-2:0] pc, tgt, seq;
  logic [SHW-1:0]  shamt;
  logic            carry, lt, ltu, eq, br, br_t, jmp;

  assign a     = req_q.a[XLEN-1:0];
  assign b     = req_q.b[XLEN-1:0];
  assign pc    = req_q.pc[XLEN-2:0];
  assign shamt = b[SHW-1:0];
  assign sum   = a + b;
  assign {carry, diff} = {1'b0, a} + {1'b0, ~b} + (XLEN+1)'(1);
  assign lt    = diff[XLEN-1] ^ ((a[XLEN-1] ^ b[XLEN-1]) & (diff[XLEN-1] ^ a[XLEN-1]));
  assign ltu   = ~carry;
  assign eq    = (a == b);
  assign tgt   = pc + {{(XLEN-1-BRIMM_W){req_q.brimm[BRIMM_W-1]}}, req_q.brimm};
  assign seq   = pc + (XLEN-1)'(req_q.pc4 ? 2 : 1);

  always_comb begin
    res  = '0;
    br   = 1'b0;
    br_t = 1'b0;
    jmp  = 1'b0;
    case (req_q.op)
      OP_ADD:  res = sum;
      OP_SUB:  res = diff;
      OP_SLT:  res = XLEN'(lt);
      OP_SLTU: res = XLEN'(ltu);
      OP_SLL:  res = a << shamt;
      OP_SRL:  res = a >> shamt;
      OP_SRA:  res = XLEN'($signed(a) >>> shamt);
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_XOR:  res = a ^ b;
      OP_BEQ:  begin br = 1'b1; br_t = eq;   end
      OP_BNE:  begin br = 1'b1; br_t = ~eq;  end
      OP_BLT:  begin br = 1'b1; br_t = lt;   end
      OP_BGE:  begin br = 1'b1; br_t = ~lt;  end
      OP_BLTU: begin br = 1'b1; br_t = ltu;  end
      OP_BGEU: begin br = 1'b1; br_t = ~ltu; end
      OP_JAL, OP_JALR: begin jmp = 1'b1; res = {seq, 1'b0}; end
`ifdef EXU_ALU_BITMANIP_EN
      OP_ANDN: res = a & ~b;
      OP_ORN:  res = a | ~b;
      OP_XNOR: res = ~(a ^ b);
      OP_MIN:  res = lt  ? a : b;
      OP_MINU: res = ltu ? a : b;
      OP_MAX:  res = lt  ? b : a;
      OP_MAXU: res = ltu ? b : a;
`endif
      default: ;
    endcase
  end

  // Masked by the stage valid so an empty single-stage pipe reads all zeros.
  always_comb begin
    rsp_c = '0;
    if (v[1]) begin
      rsp_c.result = XLEN_MAX'(res);
      rsp_c.taken  = br_t | jmp;
      rsp_c.misp   = (br & (br_t ^ req_q.pred_t)) | jmp;
      rsp_c.path   = (XLEN_MAX-1)'(jmp ? sum[XLEN-1:1] : (br ? (br_t ? tgt : seq) : '0));
    end
  end

  assign rsp_q[1] = rsp_c;

  for (genvar k = 2; k <= STAGES; k++) begin : g_stage
    exu_alu_stage #(.T(alu_rsp_t)) u_stage (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (v[k-1]),
      .in_data   (rsp_q[k-1]),
      .out_valid (v[k]),
      .out_data  (rsp_q[k]),
      .out_ready (rdy[k+1])
    );
  end

  assign out_valid  = v[STAGES];
  assign out_result = rsp_q[STAGES].result[XLEN-1:0];
  assign out_taken  = rsp_q[STAGES].taken;
  assign out_misp   = rsp_q[STAGES].misp;
  assign out_path   = rsp_q[STAGES].path[XLEN-2:0];

  if (XLEN < XLEN_MAX) begin : g_narrow
    logic unused_hi;
    assign unused_hi = ^{req_q.a[XLEN_MAX-1:XLEN], req_q.b[XLEN_MAX-1:XLEN],
                         req_q.pc[XLEN_MAX-2:XLEN-1],
                         rsp_q[STAGES].result[XLEN_MAX-1:XLEN],
                         rsp_q[STAGES].path[XLEN_MAX-2:XLEN-1]};
  end

  // Saturating count of mispredicts actually handed to the consumer.
  always_ff @(posedge clk) begin
    if (rst) begin
      misp_cnt <= '0;
    end else if (out_valid & out_ready & out_misp & ~flush & ~(&misp_cnt)) begin
      misp_cnt <= misp_cnt + CNTW'(1);
    end
  end

endmodule
